// File: rtl/wolverine_mc_pkg.sv
// Shared definitions for the Wolverine MC responder.
// Holds the request and response command codes, the request size encoding,
// the response FIFO entry layout, and the sub-word write byte-mask helper.
package wolverine_mc_pkg;

  // Request commands
  localparam logic [2:0] MC_CMD_RD     = 3'd1;
  localparam logic [2:0] MC_CMD_WR     = 3'd2;
  // Response commands
  localparam logic [2:0] MC_RS_RD_DATA = 3'd2;
  localparam logic [2:0] MC_RS_WR_CMP  = 3'd3;

  // Width of the rtnctl field stored in a response entry
  localparam int unsigned MC_RTNCTL_W = 32;

  typedef enum logic [1:0] {
    McSize1B = 2'd0,
    McSize2B = 2'd1,
    McSize4B = 2'd2,
    McSize8B = 2'd3
  } mc_size_e;

  typedef struct packed {
    logic [2:0]             cmd;
    logic [3:0]             scmd;
    logic [MC_RTNCTL_W-1:0] rtnctl;
    logic [63:0]            data;
  } rsp_entry_t;

  // Bytes touched by a write of the given size at byte offset off.
  // Bytes that would fall past byte 7 are dropped, not wrapped.
  function automatic logic [7:0] mc_byte_mask(input mc_size_e size, input logic [2:0] off);
    logic [15:0] span;
    span = (16'd1 << (4'd1 << size)) - 16'd1;
    span = span << off;
    return span[7:0];
  endfunction

endpackage

// File: rtl/wolverine_rsp_fifo.sv
// Synchronous FIFO used to queue MC responses.
// Ports:
//   clk_i, reset_i      clock and synchronous active-high reset
//   push_i, wdata_i     write side; a push is always taken
//   pop_i               read side; ignored while empty
//   rdata_o             head entry (valid while !empty_o)
//   empty_o, full_o     status flags
//   count_o             number of stored entries
// Push and pop in the same cycle leave the count unchanged, including when full.
module wolverine_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(push_i && full_o && !pop_i))
        else $error("wolverine_rsp_fifo: push into full FIFO");
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(Depth));
  assign count_o = count_q;

endmodule

// File: rtl/wolverine_mc_responder.sv
// Memory-side responder for the Wolverine MC port, backed by a local 64-bit RAM.
// Ports:
//   clk, i_reset                   clock and synchronous active-high reset
//   mc_rq_*                        request from the shim (always accepted)
//   mc_rq_stall                    registered back-pressure to the requester
//   mc_rs_*                        response to the shim, mc_rs_stall holds it off
//   mc_rq_flush, mc_rs_flush_cmplt flush request pulse and completion pulse
//   err_unsupported                sticky flag for an unsupported request command
// Request accepted at t -> pipeline register -> FIFO at t+1 -> response from t+2.
module wolverine_mc_responder
  import wolverine_mc_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned RSP_DEPTH    = 16,
  parameter int unsigned STALL_SLACK  = 4,
  parameter int unsigned RTNCTL_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    mc_rq_vld,
  input  logic [RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  input  logic [63:0]             mc_rq_data,
  input  logic [47:0]             mc_rq_vadr,
  input  logic [1:0]              mc_rq_size,
  input  logic [2:0]              mc_rq_cmd,
  input  logic [3:0]              mc_rq_scmd,
  output logic                    mc_rq_stall,
  output logic                    mc_rs_vld,
  output logic [2:0]              mc_rs_cmd,
  output logic [3:0]              mc_rs_scmd,
  output logic [63:0]             mc_rs_data,
  output logic [RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic                    mc_rs_stall,
  input  logic                    mc_rq_flush,
  output logic                    mc_rs_flush_cmplt,
  output logic                    err_unsupported
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [63:0]   mem_q [MEM_WORDS];
  logic [AW-1:0] word;
  logic [2:0]    off;
  logic          is_rd, is_wr, is_bad;
  logic [7:0]    byte_en;
  logic [63:0]   wr_data;

  rsp_entry_t    pipe_q, pipe_d, head;
  logic          pipe_vld_q, pipe_vld_d;
  logic          stall_q, stall_d, err_q, err_d, pending_q, pending_d;
  logic          fifo_empty, fifo_full, rs_vld, flush_cmplt;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occ_next;

  // Upper address bits wrap modulo MEM_WORDS and are deliberately ignored.
  logic unused_sig;
  assign unused_sig = ^{mc_rq_vadr[47:3+AW], fifo_full};

  always_comb begin
    word    = mc_rq_vadr[3 +: AW];
    off     = mc_rq_vadr[2:0];
    is_rd   = mc_rq_vld && (mc_rq_cmd == MC_CMD_RD);
    is_wr   = mc_rq_vld && (mc_rq_cmd == MC_CMD_WR);
    is_bad  = mc_rq_vld && !(mc_rq_cmd == MC_CMD_RD) && !(mc_rq_cmd == MC_CMD_WR);
    byte_en = mc_byte_mask(mc_size_e'(mc_rq_size), off);
    wr_data = mc_rq_data << {off, 3'b000};
  end

  // RAM has no reset; a write lands at the end of the accept cycle, so a read
  // accepted in the following cycle already sees it.
  always_ff @(posedge clk) begin
    if (is_wr) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem_q[word][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    pipe_vld_d    = is_rd || is_wr;
    pipe_d        = '0;
    pipe_d.cmd    = is_rd ? MC_RS_RD_DATA : MC_RS_WR_CMP;
    pipe_d.scmd   = mc_rq_scmd;
    pipe_d.rtnctl = MC_RTNCTL_W'(mc_rq_rtnctl);
    pipe_d.data   = is_rd ? mem_q[word] : 64'd0;

    rs_vld = !fifo_empty && !mc_rs_stall;

    // Occupancy as it will stand next cycle: FIFO after this cycle's push/pop
    // plus whatever enters the pipeline register now.
    occ_next = OW'(fifo_count) + OW'(pipe_vld_q) - OW'(rs_vld) + OW'(pipe_vld_d);
    stall_d  = (occ_next >= OW'(RSP_DEPTH - STALL_SLACK));

    err_d = err_q || is_bad;

    flush_cmplt = pending_q && fifo_empty && !pipe_vld_q && !mc_rq_vld;
    pending_d   = (pending_q && !flush_cmplt) || mc_rq_flush;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      pipe_vld_q <= 1'b0;
      pipe_q     <= '0;
      stall_q    <= 1'b0;
      err_q      <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_q     <= pipe_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
      pending_q  <= pending_d;
    end
  end

  wolverine_rsp_fifo #(
    .Width ($bits(rsp_entry_t)),
    .Depth (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk),
    .reset_i (i_reset),
    .push_i  (pipe_vld_q),
    .wdata_i (pipe_q),
    .pop_i   (rs_vld),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Fields show the head (held while stalled) and read as zero when empty.
  always_comb begin
    mc_rs_vld         = rs_vld;
    mc_rs_cmd         = fifo_empty ? 3'd0 : head.cmd;
    mc_rs_scmd        = fifo_empty ? 4'd0 : head.scmd;
    mc_rs_data        = fifo_empty ? 64'd0 : head.data;
    mc_rs_rtnctl      = fifo_empty ? '0 : RTNCTL_WIDTH'(head.rtnctl);
    mc_rq_stall       = stall_q;
    mc_rs_flush_cmplt = flush_cmplt;
    err_unsupported   = err_q;
  end

endmodule

// File: tb/tb_wolverine_mc_responder.sv
// Bench for wolverine_mc_responder: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a transaction-level reference model.
module tb_wolverine_mc_responder;

  localparam int unsigned MemWords = 4096;
  localparam int unsigned RspDepth = 16;
  localparam int unsigned Slack    = 4;
  localparam int          Hi       = RspDepth - Slack;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        mc_rq_vld;
  logic [31:0] mc_rq_rtnctl;
  logic [63:0] mc_rq_data;
  logic [47:0] mc_rq_vadr;
  logic [1:0]  mc_rq_size;
  logic [2:0]  mc_rq_cmd;
  logic [3:0]  mc_rq_scmd;
  logic        mc_rq_stall;
  logic        mc_rs_vld;
  logic [2:0]  mc_rs_cmd;
  logic [3:0]  mc_rs_scmd;
  logic [63:0] mc_rs_data;
  logic [31:0] mc_rs_rtnctl;
  logic        mc_rs_stall;
  logic        mc_rq_flush;
  logic        mc_rs_flush_cmplt;
  logic        err_unsupported;

  wolverine_mc_responder #(
    .MEM_WORDS    (MemWords),
    .RSP_DEPTH    (RspDepth),
    .STALL_SLACK  (Slack),
    .RTNCTL_WIDTH (32)
  ) dut (
    .clk               (clk),
    .i_reset           (i_reset),
    .mc_rq_vld         (mc_rq_vld),
    .mc_rq_rtnctl      (mc_rq_rtnctl),
    .mc_rq_data        (mc_rq_data),
    .mc_rq_vadr        (mc_rq_vadr),
    .mc_rq_size        (mc_rq_size),
    .mc_rq_cmd         (mc_rq_cmd),
    .mc_rq_scmd        (mc_rq_scmd),
    .mc_rq_stall       (mc_rq_stall),
    .mc_rs_vld         (mc_rs_vld),
    .mc_rs_cmd         (mc_rs_cmd),
    .mc_rs_scmd        (mc_rs_scmd),
    .mc_rs_data        (mc_rs_data),
    .mc_rs_rtnctl      (mc_rs_rtnctl),
    .mc_rs_stall       (mc_rs_stall),
    .mc_rq_flush       (mc_rq_flush),
    .mc_rs_flush_cmplt (mc_rs_flush_cmplt),
    .err_unsupported   (err_unsupported)
  );

  always #5 clk = ~clk;

  // Reference model: expected responses in acceptance order, each with the
  // first cycle it may appear; a sparse word memory; flush/error flags.
  typedef struct {
    logic [2:0]  cmd;
    logic [3:0]  scmd;
    logic [31:0] rtn;
    logic [63:0] data;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  logic [63:0] mem_m [int unsigned];
  int          now = 0;
  int          outstanding = 0;
  bit          pending = 0;
  bit          err_m = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned word_of(input logic [47:0] vadr);
    return int'((vadr >> 3) % MemWords);
  endfunction

  function automatic logic [63:0] model_rd(input logic [47:0] vadr);
    int unsigned w = word_of(vadr);
    return mem_m.exists(w) ? mem_m[w] : 64'hx;
  endfunction

  // Bytes off .. off+n-1 receive data bytes 0 .. n-1; anything past byte 7 is lost.
  function automatic void model_wr(input logic [47:0] vadr, input logic [1:0] size,
                                   input logic [63:0] d);
    int unsigned w   = word_of(vadr);
    int          o   = int'(vadr[2:0]);
    int          n   = 1 << size;
    logic [63:0] cur = model_rd(vadr);
    for (int b = o; b < o + n && b < 8; b++) cur[8*b +: 8] = d[8*(b-o) +: 8];
    mem_m[w] = cur;
  endfunction

  // One clock cycle: check outputs at the falling edge, then advance the model
  // with the inputs that the rising edge accepts.
  task automatic step();
    bit   ev, ec;
    exp_t e;
    ev = 0;
    ec = 0;
    @(negedge clk);
    if (!i_reset) begin
      ev = (q.size() > 0) && (q[0].rdy <= now) && !mc_rs_stall;
      ec = pending && (outstanding == 0) && !mc_rq_vld;
      chk("rs_vld", 64'(mc_rs_vld), 64'(ev));
      chk("rq_stall", 64'(mc_rq_stall), 64'(outstanding >= Hi));
      chk("flush_cmplt", 64'(mc_rs_flush_cmplt), 64'(ec));
      chk("err_unsupported", 64'(err_unsupported), 64'(err_m));
      if (q.size() > 0 && q[0].rdy <= now) begin
        chk("rs_cmd", 64'(mc_rs_cmd), 64'(q[0].cmd));
        chk("rs_scmd", 64'(mc_rs_scmd), 64'(q[0].scmd));
        chk("rs_rtnctl", 64'(mc_rs_rtnctl), 64'(q[0].rtn));
        chk("rs_data", mc_rs_data, q[0].data);
      end
    end
    @(posedge clk);
    if (i_reset) begin
      q.delete();
      outstanding = 0;
      pending = 0;
      err_m = 0;
    end else begin
      if (ev) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (mc_rq_vld) begin
        e.scmd = mc_rq_scmd;
        e.rtn  = mc_rq_rtnctl;
        e.rdy  = now + 2;
        if (mc_rq_cmd == 3'd1) begin
          e.cmd  = 3'd2;
          e.data = model_rd(mc_rq_vadr);
          q.push_back(e);
          outstanding++;
        end else if (mc_rq_cmd == 3'd2) begin
          model_wr(mc_rq_vadr, mc_rq_size, mc_rq_data);
          e.cmd  = 3'd3;
          e.data = 64'd0;
          q.push_back(e);
          outstanding++;
        end else begin
          err_m = 1;
        end
      end
      if (ec) pending = 0;
      if (mc_rq_flush) pending = 1;
    end
    now++;
    #1;
  endtask

  task automatic rq(input logic [2:0] cmd, input logic [1:0] size, input logic [47:0] vadr,
                    input logic [63:0] data, input logic [31:0] rtn);
    mc_rq_vld    = 1'b1;
    mc_rq_cmd    = cmd;
    mc_rq_size   = size;
    mc_rq_vadr   = vadr;
    mc_rq_data   = data;
    mc_rq_rtnctl = rtn;
    mc_rq_scmd   = 4'($urandom);
    step();
    mc_rq_vld    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    mc_rq_vld   = 1'b0;
    mc_rq_flush = 1'b0;
    mc_rs_stall = 1'b0;
    step();
    step();
    i_reset = 1'b0;
    chk("rst_rs_vld", 64'(mc_rs_vld), 64'd0);
    chk("rst_rq_stall", 64'(mc_rq_stall), 64'd0);
    chk("rst_flush_cmplt", 64'(mc_rs_flush_cmplt), 64'd0);
    chk("rst_err", 64'(err_unsupported), 64'd0);
    chk("rst_rs_cmd", 64'(mc_rs_cmd), 64'd0);
    chk("rst_rs_scmd", 64'(mc_rs_scmd), 64'd0);
    chk("rst_rs_data", mc_rs_data, 64'd0);
    chk("rst_rs_rtnctl", 64'(mc_rs_rtnctl), 64'd0);
  endtask

  initial begin
    logic [47:0] va;
    int          r;
    i_reset      = 1'b1;
    mc_rq_vld    = 1'b0;
    mc_rq_rtnctl = '0;
    mc_rq_data   = '0;
    mc_rq_vadr   = '0;
    mc_rq_size   = '0;
    mc_rq_cmd    = '0;
    mc_rq_scmd   = '0;
    mc_rs_stall  = 1'b0;
    mc_rq_flush  = 1'b0;
    do_reset();

    // Preload words 0..15 with full-word writes
    for (int w = 0; w < 16; w++) rq(3'd2, 2'd3, 48'(w * 8), {$urandom, $urandom}, 32'(w));
    idle(20);

    // Full write then read-after-write of the same word
    rq(3'd2, 2'd3, 48'h40, 64'hDEADBEEF_CAFEF00D, 32'h11);
    rq(3'd1, 2'd3, 48'h40, 64'd0, 32'h12);
    idle(4);

    // Byte write into a zeroed word, then a 4-byte write crossing the word end
    rq(3'd2, 2'd3, 48'h80, 64'd0, 32'h20);
    rq(3'd2, 2'd0, 48'h83, 64'hFFFF_FFFF_FFFF_FFAB, 32'h21);
    rq(3'd1, 2'd0, 48'h80, 64'd0, 32'h22);
    rq(3'd2, 2'd2, 48'h86, 64'h11223344, 32'h23);
    rq(3'd1, 2'd3, 48'h80, 64'd0, 32'h24);
    idle(4);

    // Responses held off: 12 reads raise the stall, 3 more fit in the slack
    mc_rs_stall = 1'b1;
    for (int i = 0; i < 15; i++) rq(3'd1, 2'd3, 48'(($urandom_range(15)) * 8), 64'd0, 32'h100 + 32'(i));
    idle(3);
    mc_rs_stall = 1'b0;
    idle(20);

    // Response stall toggling every cycle
    for (int i = 0; i < 8; i++) begin
      mc_rs_stall = ~mc_rs_stall;
      rq(3'd1, 2'd3, 48'(i * 8), 64'd0, 32'h200 + 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      mc_rs_stall = ~mc_rs_stall;
      step();
    end
    mc_rs_stall = 1'b0;
    idle(2);

    // Flush behind three reads, then a flush on an idle block
    for (int i = 0; i < 3; i++) rq(3'd1, 2'd3, 48'(i * 8), 64'd0, 32'h300 + 32'(i));
    mc_rq_flush = 1'b1;
    step();
    mc_rq_flush = 1'b0;
    idle(6);
    mc_rq_flush = 1'b1;
    step();
    mc_rq_flush = 1'b0;
    idle(3);

    // Second flush pulse while one is pending is absorbed
    for (int i = 0; i < 3; i++) rq(3'd1, 2'd3, 48'(i * 8), 64'd0, 32'h400 + 32'(i));
    mc_rq_flush = 1'b1;
    step();
    mc_rq_flush = 1'b0;
    step();
    mc_rq_flush = 1'b1;
    step();
    mc_rq_flush = 1'b0;
    idle(6);

    // Unsupported command: no response, sticky error
    rq(3'd5, 2'd3, 48'h40, 64'd0, 32'h500);
    idle(5);
    rq(3'd1, 2'd3, 48'h40, 64'd0, 32'h501);
    idle(4);

    // Reset with responses outstanding and a flush pending
    mc_rs_stall = 1'b1;
    for (int i = 0; i < 4; i++) rq(3'd1, 2'd3, 48'(i * 8), 64'd0, 32'h600 + 32'(i));
    idle(2);
    mc_rq_flush = 1'b1;
    step();
    mc_rq_flush = 1'b0;
    do_reset();
    idle(6);

    // Randomized traffic; requester respects the stall
    for (int i = 0; i < 600; i++) begin
      mc_rs_stall = ($urandom_range(99) < 30);
      mc_rq_flush = ($urandom_range(99) < 3);
      if (outstanding < Hi && $urandom_range(99) < 60) begin
        r  = int'($urandom_range(19));
        va = {33'($urandom), 12'($urandom_range(15)), 3'($urandom)};
        rq((r < 9) ? 3'd1 : (r < 18) ? 3'd2 : ((r == 18) ? 3'd5 : 3'd0),
           2'($urandom), va, {$urandom, $urandom}, $urandom);
      end else begin
        step();
      end
    end
    mc_rs_stall = 1'b0;
    mc_rq_flush = 1'b0;
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wolverine_mc_responder.md
Name: wolverine_mc_responder

Overview:
- Memory-side responder for the Wolverine MC port: accepts mc_rq_* requests issued by the shim and returns mc_rs_* responses.
- Backed by a local 64-bit word RAM.
- Used as the MC model in simulation and in standalone FPGA bring-up, in place of the Convey memory controller.
- Implements request stall back-pressure, response stall, rtnctl echo, sub-word writes and flush completion.

Parameters:
MEM_WORDS, 4096, backing RAM depth in 64-bit words (power of 2)
RSP_DEPTH, 16, response FIFO entries (power of 2, >= 8)
STALL_SLACK, 4, free FIFO entries reserved for requests still arriving after mc_rq_stall rises
RTNCTL_WIDTH, 32, rtnctl width

Ports:
clk  in  1  clock
i_reset  in  1  synchronous active-high reset
mc_rq_vld  in  1  request valid
mc_rq_rtnctl  in  RTNCTL_WIDTH  requester tag, echoed in response
mc_rq_data  in  64  write data, right-aligned
mc_rq_vadr  in  48  byte address
mc_rq_size  in  2  0=1B, 1=2B, 2=4B, 3=8B
mc_rq_cmd  in  3  1=RD, 2=WR, other=unsupported
mc_rq_scmd  in  4  sub-command, echoed
mc_rq_stall  out  1  registered back-pressure to requester
mc_rs_vld  out  1  response valid
mc_rs_cmd  out  3  2=RD_DATA, 3=WR_CMP
mc_rs_scmd  out  4  echoed scmd
mc_rs_data  out  64  read data (full word); 0 for WR_CMP
mc_rs_rtnctl  out  RTNCTL_WIDTH  echoed rtnctl
mc_rs_stall  in  1  requester cannot take a response this cycle
mc_rq_flush  in  1  one-cycle flush request pulse
mc_rs_flush_cmplt  out  1  one-cycle pulse, flush done
err_unsupported  out  1  sticky: an unsupported cmd was received

Behaviour:
- Clock and reset: one clock clk; reset i_reset is synchronous, active-high.
- Reset values:
  - All outputs reset to 0.
  - FIFO and pipeline are emptied; flush_pending is cleared.
  - RAM contents are not reset.
  - Reset mid-operation discards all outstanding responses; no flush_cmplt is issued for an in-progress flush.
- Accept rule: every cycle with mc_rq_vld=1 is accepted unconditionally, whatever the mc_rq_stall value. Requests are never dropped.
- Address mapping:
  - word = vadr[3 +: log2(MEM_WORDS)]; upper bits are ignored (wraps modulo MEM_WORDS).
  - byte offset off = vadr[2:0].
- WR:
  - Byte mask = ((1<<(1<<size))-1) << off, truncated to 8 bits. Data is placed at mc_rq_data << (8*off).
  - Misaligned writes that cross the word boundary are truncated, never wrapped.
  - RAM is written in the accept cycle. A WR_CMP is pushed with rtnctl and scmd, data 0.
- RD:
  - RAM is read in the accept cycle; the full 64-bit word is returned regardless of size.
  - Read-after-write ordering is preserved: an RD accepted the cycle after a WR to the same word returns the new data (write-first RAM or bypass).
- Unsupported cmd: no RAM access and no response; err_unsupported is set (sticky until reset).
- Pipeline:
  - Accept at cycle t → one register stage → FIFO write at t+1 → earliest mc_rs_vld at t+2.
  - Responses are in strict acceptance order.
- Response handshake:
  - mc_rs_vld = FIFO non-empty AND !mc_rs_stall. The head is popped in every cycle where mc_rs_vld=1.
  - mc_rs_* data fields show the FIFO head and are stable while stalled.
- Back-pressure:
  - occ = FIFO count + pipeline-stage valid.
  - mc_rq_stall is registered: next = (occ_next >= RSP_DEPTH - STALL_SLACK).
  - The FIFO must not overflow if the requester sends up to STALL_SLACK-1 further requests after stall rises. A push into a full FIFO is a design error: assertion in simulation.
- Simultaneous push and pop: count is unchanged. A full FIFO with a pop and a push in the same cycle is legal.
- Flush:
  - mc_rq_flush sets flush_pending.
  - While flush_pending is set, mc_rs_flush_cmplt pulses for exactly one cycle in the first cycle where FIFO empty, pipeline empty, and no request accepted. flush_pending then clears.
  - A flush pulse while already pending is absorbed, giving one cmplt.
  - A flush arriving with everything already empty gives cmplt 1 cycle later.

Decomposition:
- Package wolverine_mc_pkg:
  - MC_CMD_RD=1, MC_CMD_WR=2, MC_RS_RD_DATA=2, MC_RS_WR_CMP=3.
  - Size encodings.
  - Response entry struct: cmd, scmd, rtnctl, data.
- Sub-module wolverine_rsp_fifo: synchronous FIFO with count, full/empty, same-cycle push/pop. Parameterised on width and depth.

Test Plan:
- WR size=3 vadr=0x40 data=0xDEADBEEF_CAFEF00D rtnctl=0x11, then RD vadr=0x40 rtnctl=0x12 → WR_CMP rtnctl 0x11 at t+2, then RD_DATA 0xDEADBEEFCAFEF00D rtnctl 0x12 one cycle later.
- Byte write: WR size=0 vadr=0x43 data=0xAB over a word of all 0 → subsequent RD returns 0x00000000AB000000. WR size=2 vadr=0x46 (crossing) → only bytes 6,7 written.
- Hold mc_rs_stall=1 while sending 12 RDs back-to-back (RSP_DEPTH=16, SLACK=4) → mc_rq_stall rises when occ reaches 12. No response while stalled. After release, 12 responses in order with correct rtnctl and no overflow assertion.
- Toggle mc_rs_stall every other cycle during 8 RDs → mc_rs_vld never high while mc_rs_stall is high; data held stable; all 8 delivered in order.
- Flush after 3 RDs, rs_stall=0 → flush_cmplt pulses exactly once, in the cycle after the 3rd response pops. Second flush with idle block → cmplt one cycle later.
- cmd=5 request → no response; err_unsupported=1 and it stays high. Reset with 4 responses pending → outputs 0 next cycle, no stale responses afterwards.
